// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner select for a shared 3-to-8 decoder, with hold timeout.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic [7:0] grant,
  output logic       timeout,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] last, last_n, sel_n, pick;
  logic [7:0] hold_cnt, hold_n;
  logic sel_en_n, timeout_n, hit_limit, release_g;
  always_comb begin
    pick = last;
    // scan from farthest to nearest so the nearest set bit after last wins
    for (int k = 8; k >= 1; k--)
      if (req[last + 3'(k)]) pick = last + 3'(k);
    hit_limit = (MAX_HOLD != 0) && (hold_cnt == 8'(MAX_HOLD - 1));
    release_g = done || !req[sel] || hit_limit;
    state_n   = state;
    sel_n     = sel;
    sel_en_n  = sel_en;
    last_n    = last;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_n  = GRANT;
        sel_n    = pick;
        sel_en_n = 1'b1;
        hold_n   = 8'd0;
      end
    end else if (release_g) begin
      state_n   = IDLE;
      sel_en_n  = 1'b0;
      last_n    = sel;
      timeout_n = hit_limit && !done && req[sel];
    end else begin
      hold_n = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 3'd0;
      sel_en   <= 1'b0;
      grant    <= 8'd0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      last     <= 3'd7;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      sel_en   <= sel_en_n;
      grant    <= sel_en_n ? (8'd1 << sel_n) : 8'd0;
      timeout  <= timeout_n;
      busy     <= sel_en_n;
      last     <= last_n;
      hold_cnt <= hold_n;
    end
  end
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed vector table plus hand sequences for timeout and saturation.
module tb_decoder_rr_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic [7:0] req, req4, req0;
  logic done, done4, done0;
  logic [2:0] sel, sel4, sel0;
  logic sel_en, sel_en4, sel_en0;
  logic [7:0] grant, grant4, grant0;
  logic timeout, timeout4, timeout0;
  logic busy, busy4, busy0;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decoder_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done), .sel(sel),
    .sel_en(sel_en), .grant(grant), .timeout(timeout), .busy(busy));
  decoder_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clock(clock), .reset(reset), .req(req4), .done(done4), .sel(sel4),
    .sel_en(sel_en4), .grant(grant4), .timeout(timeout4), .busy(busy4));
  decoder_rr_arbiter #(.MAX_HOLD(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .done(done0), .sel(sel0),
    .sel_en(sel_en0), .grant(grant0), .timeout(timeout0), .busy(busy0));

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       to;
  } vec_t;
  vec_t v[$];

  function automatic void add(logic [7:0] r, logic d, logic rs, logic e, logic [2:0] s, logic [7:0] g, logic t);
    vec_t x;
    x.req = r; x.done = d; x.rst = rs; x.en = e; x.sel = s; x.grant = g; x.to = t;
    v.push_back(x);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bit held;
    reset = 1'b1; req = 8'hFF; done = 1'b0;
    req4 = 8'h00; done4 = 1'b0; req0 = 8'h00; done0 = 1'b0;
    tick;
    chk("reset_sel", sel, 0);
    chk("reset_sel_en", sel_en, 0);
    chk("reset_grant", grant, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i <= 8; i++) begin
      add(8'hFF, 1'b0, 1'b0, 1'b1, 3'(i), 8'd1 << (i % 8), 1'b0);
      add(8'hFF, 1'b1, 1'b0, 1'b0, 3'(i), 8'h00, 1'b0);
    end
    add(8'hA0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0);
    add(8'hA0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0);
    add(8'hA0, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0);
    add(8'hA0, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0);
    add(8'hA0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0);
    add(8'hA0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0);
    add(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
    add(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0);
    add(8'h18, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0);
    add(8'h18, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
    add(8'h40, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0);
    add(8'h40, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0);
    add(8'h41, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    add(8'h41, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
    add(8'h41, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    add(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    add(8'h41, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0);

    foreach (v[i]) begin
      req = v[i].req; done = v[i].done; reset = v[i].rst;
      tick;
      chk($sformatf("vec%0d_sel_en", i), sel_en, v[i].en);
      chk($sformatf("vec%0d_sel", i), sel, v[i].sel);
      chk($sformatf("vec%0d_grant", i), grant, v[i].grant);
      chk($sformatf("vec%0d_timeout", i), timeout, v[i].to);
      chk($sformatf("vec%0d_busy", i), busy, v[i].en);
    end
    reset = 1'b0; req = 8'h00; done = 1'b0;

    req4 = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("hold%0d_sel_en", i), sel_en4, 1);
      chk($sformatf("hold%0d_timeout", i), timeout4, 0);
    end
    chk("hold_sel", sel4, 2);
    tick;
    chk("limit_sel_en", sel_en4, 0);
    chk("limit_timeout", timeout4, 1);
    chk("limit_grant", grant4, 0);
    tick;
    chk("regrant_sel_en", sel_en4, 1);
    chk("regrant_sel", sel4, 2);
    chk("regrant_timeout", timeout4, 0);
    tick; tick; tick;
    chk("pre_coincide_sel_en", sel_en4, 1);
    done4 = 1'b1;
    tick;
    done4 = 1'b0;
    chk("coincide_sel_en", sel_en4, 0);
    chk("coincide_timeout", timeout4, 0);
    req4 = 8'h00;

    req0 = 8'h02;
    tick;
    chk("nolimit_first_sel", sel0, 1);
    held = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (!sel_en0 || timeout0 || grant0 != 8'h02) held = 1'b0;
    end
    chk("nolimit_held", held, 1);
    chk("nolimit_hold_cnt", dut0.hold_cnt, 255);
    chk("nolimit_grant", grant0, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
